unary_program_runner: RTL and testbench
=======================================

# unary_program_runner

Parametrised on-chip program runner and self-checker for FPGA regression tests. It executes a loaded program of move, unary-logic and arithmetic, output and jump instructions against a local memory, streams every output word, then compares the output channel with a loaded expected-value table. It raises `finished` and `success` for board-level LEDs. It replaces the per-test hard-coded runners with one block that is loaded over a write port.

## Interface
- `WIDTH`, 12, data word width
- `NLOCAL`, 16, local memory words; `AW = $clog2(NLOCAL)`
- `NPROG`, 16, program memory words; `PW = $clog2(NPROG)`
- `NOUT`, 8, output channel and expected-table words; `OW = $clog2(NOUT)`
- `MAX_STEPS`, 64, executed-instruction limit before timeout
- Instruction word = `{op[2:0], tgt[AW-1:0], imm[WIDTH-1:0]}`. `src` is `imm[AW-1:0]`; the jump target is `imm[PW-1:0]`.

- `clock` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `run` in 1: start pulse, sampled in IDLE or DONE
- `prog_we` in 1: program write strobe
- `prog_addr` in PW: program write address
- `prog_data` in 3+AW+WIDTH: instruction word
- `exp_we` in 1: expected-table write strobe
- `exp_addr` in OW: expected-table address
- `exp_data` in WIDTH: expected value
- `exp_count` in OW+1: number of expected outputs, sampled at run
- `out_valid` out 1: one-cycle pulse per OUT
- `out_data` out WIDTH: output word
- `out_count` out OW+1: outputs produced this run, saturating at NOUT
- `finished` out 1: high in DONE
- `success` out 1: pass result, valid while finished
- `timeout` out 1: MAX_STEPS reached without halt
- `overflow` out 1: more than NOUT OUTs executed

## Operation
- States: IDLE, EXEC, CHECK, DONE. Reset forces IDLE, clears every output, `ip`, the step counter and the output position. Program, expected table and local memory are not cleared.
- Loads: `prog_we` and `exp_we` write on the edge only in IDLE or DONE. They are ignored in EXEC and CHECK.
- `run` in IDLE or DONE:
  - sets `ip=0`, `steps=0`, `outPos=0`
  - clears `out_count`, `finished`, `success`, `timeout`, `overflow`
  - latches `exp_count`
  - moves to EXEC
- EXEC executes `prog[ip]` once per cycle. All arithmetic is modulo 2^WIDTH.
  - 0 HALT: go to CHECK.
  - 1 MOVI: `L[tgt]=imm`.
  - 2 NOT: `L[tgt] = (L[src]==0) ? 1 : 0` (logical).
  - 3 INV: `L[tgt] = ~L[src]`.
  - 4 NEG: `L[tgt] = -L[src]`.
  - 5 INC: `L[tgt] = L[src]+1`.
  - 6 OUT: `out_data = L[src]`, pulse `out_valid`, `outMem[outPos] = L[src]`, `outPos = (outPos+1) % NOUT`. If `out_count == NOUT`, set `overflow`; otherwise increment `out_count`.
  - 7 JMP: `ip = imm[PW-1:0]`.
  - Non-JMP instructions advance `ip = ip+1`.
- Executing address NPROG-1 without a HALT or JMP is an implicit halt: go to CHECK.
- `steps` increments on every EXEC cycle. If `steps` reaches MAX_STEPS and the instruction executed on that edge is not HALT, go directly to DONE with `timeout=1` and `success=0`. The implicit halt at NPROG-1 does not suppress the timeout.
- A read-after-write to the same L address in consecutive instructions sees the new value. No hazard exists because there is one instruction per cycle.
- CHECK:
  - If `out_count != exp_count` or `overflow`: one cycle, then DONE with `success=0`.
  - Otherwise compare `outMem[i]` against `exp[i]` for i = 0..exp_count-1, one per cycle. Any mismatch clears the internal pass flag.
  - `exp_count = 0` takes one cycle.
  - Then DONE with `success` = pass flag.
- DONE: `finished=1`, outputs held until `run` or `reset`.
- `run` while in EXEC or CHECK is ignored.
- `reset` mid-run aborts to IDLE within the same edge.

## Timing
- `run` is sampled at edge 0, and the state becomes EXEC after edge 0.
- Instructions execute on edges 1..E, where E counts executed instructions including HALT.
- Compares occur on edges E+1..E+C, where C = max(exp_count, 1).
- `finished` and `success` are registered and become high after edge E+C.
- `out_valid` and `out_data` are registered and high for exactly the cycle after the OUT edge.
- On timeout, `finished` and `timeout` become high after edge MAX_STEPS.

## Test plan
- Load MOVI 0,3; NOT 1,0; NOT 2,1; OUT 0; OUT 1; OUT 2; HALT, with expected values 3,0,1 and `exp_count=3`.
  - `out_data` sequence is 3,0,1.
  - `finished` rises after edge 10; `success=1`, `timeout=0`, `overflow=0`.
- Same program with expected value [1] = 5: `finished` after edge 10, `success=0`.
- Same program with `exp_count=2`: one CHECK cycle, `finished` after edge 8, `success=0`.
- Load MOVI 0,4095; INC 1,0; NEG 2,0; INV 3,0; OUT 1; OUT 2; OUT 3; HALT, with expected values 0,1,0: `success=1`.
- Program JMP 0 at address 0, MAX_STEPS=64: `timeout=1` and `finished` high after edge 64, `success=0`, `out_count=0`.
- Nine OUTs with NOUT=8: `overflow=1`, `out_count=8`, `success=0`.
- Assert `reset` at edge 3 of the first program: all outputs 0 and state IDLE the following cycle. A rerun passes.

Source files
------------

// File: rtl/unary_program_runner.sv
// unary_program_runner: loadable program executor with an output-stream self-check.
// Runs one instruction per cycle from program memory against a small local
// memory, records every OUT word, then compares the recorded words with a
// loaded expected table and reports finished/success/timeout/overflow.
module unary_program_runner #(
  parameter int WIDTH     = 12,
  parameter int NLOCAL    = 16,
  parameter int NPROG     = 16,
  parameter int NOUT      = 8,
  parameter int MAX_STEPS = 64,
  localparam int AW = $clog2(NLOCAL),
  localparam int PW = $clog2(NPROG),
  localparam int OW = $clog2(NOUT),
  localparam int IW = 3 + AW + WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             exp_we,
  input  logic [OW-1:0]    exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [OW:0]      exp_count,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OW:0]      out_count,
  output logic             finished,
  output logic             success,
  output logic             timeout,
  output logic             overflow
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  localparam logic [2:0] OP_HALT = 3'd0;
  localparam logic [2:0] OP_MOVI = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_INV  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CHECK, S_DONE} state_t;

  // Storage: none of these arrays is cleared by reset.
  logic [IW-1:0]    prog_mem  [NPROG];
  logic [WIDTH-1:0] exp_mem   [NOUT];
  logic [WIDTH-1:0] local_mem [NLOCAL];
  logic [WIDTH-1:0] out_mem   [NOUT];

  state_t           state_reg, state_next;
  logic [PW-1:0]    ip_reg, ip_next;
  logic [SW-1:0]    steps_reg, steps_next;
  logic [OW-1:0]    out_pos_reg, out_pos_next;
  logic [OW:0]      exp_count_reg, exp_count_next;
  logic [OW-1:0]    chk_idx_reg, chk_idx_next;
  logic             pass_reg, pass_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [OW:0]      out_count_reg, out_count_next;
  logic             finished_reg, finished_next;
  logic             success_reg, success_next;
  logic             timeout_reg, timeout_next;
  logic             overflow_reg, overflow_next;

  logic             local_we;
  logic [AW-1:0]    local_waddr;
  logic [WIDTH-1:0] local_wdata;
  logic             out_we;

  // Instruction decode of the current program word (asynchronous read so a
  // new instruction issues every cycle).
  logic [IW-1:0]    instr;
  logic [2:0]       op;
  logic [AW-1:0]    tgt;
  logic [WIDTH-1:0] imm;
  logic [AW-1:0]    src;
  logic [WIDTH-1:0] src_val;
  logic [SW-1:0]    steps_inc;
  logic             exec_timeout;
  logic             exec_halt;
  logic             loads_ok;
  logic             start;
  logic             count_bad;
  logic [OW:0]      last_idx;
  logic             word_match;
  logic             chk_last;

  assign instr        = prog_mem[ip_reg];
  assign op           = instr[IW-1 -: 3];
  assign tgt          = instr[WIDTH +: AW];
  assign imm          = instr[WIDTH-1:0];
  assign src          = imm[AW-1:0];
  assign src_val      = local_mem[src];
  assign steps_inc    = steps_reg + SW'(1);
  // Timeout wins over the implicit halt at the last address, but not over HALT.
  assign exec_timeout = (steps_inc == SW'(MAX_STEPS)) && (op != OP_HALT);
  assign exec_halt    = (op == OP_HALT) || ((op != OP_JMP) && (ip_reg == PW'(NPROG - 1)));
  assign loads_ok     = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign start        = loads_ok && run;
  assign count_bad    = (out_count_reg != exp_count_reg) || overflow_reg;
  assign last_idx     = exp_count_reg - (OW+1)'(1);
  assign word_match   = (out_mem[chk_idx_reg] == exp_mem[chk_idx_reg]);
  assign chk_last     = ({1'b0, chk_idx_reg} == last_idx);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (run) state_next = S_EXEC;
      S_EXEC: begin
        if (exec_timeout)   state_next = S_DONE;
        else if (exec_halt) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (count_bad || exp_count_reg == '0 || chk_last) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output next-values.
  always_comb begin
    ip_next        = ip_reg;
    steps_next     = steps_reg;
    out_pos_next   = out_pos_reg;
    exp_count_next = exp_count_reg;
    chk_idx_next   = chk_idx_reg;
    pass_next      = pass_reg;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    out_count_next = out_count_reg;
    finished_next  = finished_reg;
    success_next   = success_reg;
    timeout_next   = timeout_reg;
    overflow_next  = overflow_reg;
    local_we       = 1'b0;
    local_waddr    = tgt;
    local_wdata    = '0;
    out_we         = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          ip_next        = '0;
          steps_next     = '0;
          out_pos_next   = '0;
          exp_count_next = exp_count;
          chk_idx_next   = '0;
          pass_next      = 1'b1;
          out_count_next = '0;
          finished_next  = 1'b0;
          success_next   = 1'b0;
          timeout_next   = 1'b0;
          overflow_next  = 1'b0;
        end
      end
      S_EXEC: begin
        steps_next = steps_inc;
        ip_next    = ip_reg + PW'(1);
        case (op)
          OP_MOVI: begin local_we = 1'b1; local_wdata = imm; end
          OP_NOT:  begin local_we = 1'b1; local_wdata = (src_val == '0) ? WIDTH'(1) : '0; end
          OP_INV:  begin local_we = 1'b1; local_wdata = ~src_val; end
          OP_NEG:  begin local_we = 1'b1; local_wdata = -src_val; end
          OP_INC:  begin local_we = 1'b1; local_wdata = src_val + WIDTH'(1); end
          OP_OUT: begin
            out_we         = 1'b1;
            out_valid_next = 1'b1;
            out_data_next  = src_val;
            out_pos_next   = (out_pos_reg == OW'(NOUT - 1)) ? '0 : out_pos_reg + OW'(1);
            if (out_count_reg == (OW+1)'(NOUT)) overflow_next = 1'b1;
            else                                out_count_next = out_count_reg + (OW+1)'(1);
          end
          OP_JMP:  ip_next = imm[PW-1:0];
          default: ;
        endcase
        if (exec_timeout) begin
          timeout_next  = 1'b1;
          finished_next = 1'b1;
          success_next  = 1'b0;
        end
      end
      S_CHECK: begin
        if (count_bad) begin
          finished_next = 1'b1;
          success_next  = 1'b0;
        end else if (exp_count_reg == '0) begin
          finished_next = 1'b1;
          success_next  = pass_reg;
        end else begin
          pass_next    = pass_reg & word_match;
          chk_idx_next = chk_idx_reg + OW'(1);
          if (chk_last) begin
            finished_next = 1'b1;
            success_next  = pass_reg & word_match;
          end
        end
      end
      default: ;
    endcase
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ip_reg        <= '0;
      steps_reg     <= '0;
      out_pos_reg   <= '0;
      exp_count_reg <= '0;
      chk_idx_reg   <= '0;
      pass_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      finished_reg  <= 1'b0;
      success_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      ip_reg        <= ip_next;
      steps_reg     <= steps_next;
      out_pos_reg   <= out_pos_next;
      exp_count_reg <= exp_count_next;
      chk_idx_reg   <= chk_idx_next;
      pass_reg      <= pass_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_count_reg <= out_count_next;
      finished_reg  <= finished_next;
      success_reg   <= success_next;
      timeout_reg   <= timeout_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Memory writes: host loads only while idle/done, execution writes in EXEC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (prog_we && loads_ok) prog_mem[prog_addr] <= prog_data;
      if (exp_we && loads_ok)  exp_mem[exp_addr]   <= exp_data;
      if (local_we)            local_mem[local_waddr] <= local_wdata;
      if (out_we)              out_mem[out_pos_reg]   <= src_val;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign finished  = finished_reg;
  assign success   = success_reg;
  assign timeout   = timeout_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_unary_program_runner.sv
// Directed testbench for unary_program_runner with default parameters.
module tb_unary_program_runner;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [18:0] prog_data;
  logic        exp_we;
  logic [2:0]  exp_addr;
  logic [11:0] exp_data;
  logic [3:0]  exp_count;
  logic        out_valid;
  logic [11:0] out_data;
  logic [3:0]  out_count;
  logic        finished;
  logic        success;
  logic        timeout;
  logic        overflow;

  int checks = 0;
  int fails  = 0;
  logic [11:0] out_q[$];
  int fin_edge;
  logic [1:0] st;

  unary_program_runner dut (
    .clock(clock), .reset(reset), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_count(exp_count),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .finished(finished), .success(success), .timeout(timeout), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [18:0] ins(input int op, input int tgt, input int imm);
    return {op[2:0], tgt[3:0], imm[11:0]};
  endfunction

  task automatic wp(input int a, input logic [18:0] d);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic we(input int a, input int d);
    exp_we = 1'b1; exp_addr = a[2:0]; exp_data = d[11:0];
    tick();
    exp_we = 1'b0;
  endtask

  // Pulse run (edge 0), then count edges until finished, capturing outputs.
  task automatic do_run(output int fe);
    out_q.delete();
    fe = -1;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (out_valid) out_q.push_back(out_data);
      if (finished) begin
        fe = e;
        break;
      end
    end
  endtask

  task automatic load_prog1();
    wp(0, ins(1, 0, 3));
    wp(1, ins(2, 1, 0));
    wp(2, ins(2, 2, 1));
    wp(3, ins(6, 0, 0));
    wp(4, ins(6, 0, 1));
    wp(5, ins(6, 0, 2));
    wp(6, ins(0, 0, 0));
    we(0, 3); we(1, 0); we(2, 1);
    exp_count = 4'd3;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_count = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_finished", finished, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_valid", out_valid, 0);

    // Program 1: outputs 3,0,1, all match.
    load_prog1();
    do_run(fin_edge);
    $display("run p1: fin_edge=%0d success=%0d outs=%0d", fin_edge, success, out_q.size());
    check("p1_fin_edge", fin_edge, 10);
    check("p1_success", success, 1);
    check("p1_timeout", timeout, 0);
    check("p1_overflow", overflow, 0);
    check("p1_nouts", out_q.size(), 3);
    if (out_q.size() == 3) begin
      check("p1_out0", out_q[0], 3);
      check("p1_out1", out_q[1], 0);
      check("p1_out2", out_q[2], 1);
    end

    // Expected[1] wrong.
    we(1, 5);
    do_run(fin_edge);
    $display("run p1 bad exp: fin_edge=%0d success=%0d", fin_edge, success);
    check("p1bad_fin_edge", fin_edge, 10);
    check("p1bad_success", success, 0);
    we(1, 0);

    // Count mismatch: one CHECK cycle.
    exp_count = 4'd2;
    do_run(fin_edge);
    $display("run p1 cnt2: fin_edge=%0d success=%0d", fin_edge, success);
    check("cnt_fin_edge", fin_edge, 8);
    check("cnt_success", success, 0);

    // Program 2: wrap-around arithmetic.
    wp(0, ins(1, 0, 4095));
    wp(1, ins(5, 1, 0));
    wp(2, ins(4, 2, 0));
    wp(3, ins(3, 3, 0));
    wp(4, ins(6, 0, 1));
    wp(5, ins(6, 0, 2));
    wp(6, ins(6, 0, 3));
    wp(7, ins(0, 0, 0));
    we(0, 0); we(1, 1); we(2, 0);
    exp_count = 4'd3;
    do_run(fin_edge);
    $display("run p2: fin_edge=%0d success=%0d", fin_edge, success);
    check("p2_fin_edge", fin_edge, 11);
    check("p2_success", success, 1);
    if (out_q.size() == 3) check("p2_out1", out_q[1], 1);
    else check("p2_nouts", out_q.size(), 3);

    // Infinite loop: timeout.
    wp(0, ins(7, 0, 0));
    do_run(fin_edge);
    $display("run jmp: fin_edge=%0d timeout=%0d success=%0d", fin_edge, timeout, success);
    check("to_fin_edge", fin_edge, 64);
    check("to_timeout", timeout, 1);
    check("to_success", success, 0);
    check("to_out_count", out_count, 0);

    // Nine OUTs: overflow.
    wp(0, ins(1, 0, 7));
    for (int a = 1; a <= 9; a++) wp(a, ins(6, 0, 0));
    wp(10, ins(0, 0, 0));
    exp_count = 4'd8;
    do_run(fin_edge);
    $display("run ovf: fin_edge=%0d overflow=%0d out_count=%0d", fin_edge, overflow, out_count);
    check("ovf_fin_edge", fin_edge, 12);
    check("ovf_overflow", overflow, 1);
    check("ovf_out_count", out_count, 8);
    check("ovf_success", success, 0);
    check("ovf_pulses", out_q.size(), 9);

    // Reset at edge 3 of program 1, then rerun.
    load_prog1();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    st = dut.state_reg;
    $display("reset mid-run: state=%0d finished=%0d out_count=%0d", st, finished, out_count);
    check("mid_rst_state", st, 0);
    check("mid_rst_finished", finished, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_timeout", timeout, 0);
    do_run(fin_edge);
    $display("rerun p1: fin_edge=%0d success=%0d", fin_edge, success);
    check("rerun_fin_edge", fin_edge, 10);
    check("rerun_success", success, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
